// File: rtl/core_align_sub_pipe.sv
// Two-stage magnitude order/align/subtract for the effective-subtraction path.
// Stage 1 swaps operands so big >= small; stage 2 aligns small and subtracts.
module core_align_sub_pipe #(
  parameter int N                    = 16,
  parameter int MANT_SIZE            = N / 2,
  parameter int TE_SIZE              = $clog2(N) + 2,
  parameter int MANT_SUB_RESULT_SIZE = 2 * MANT_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            sign_a,
  input  logic                            sign_b,
  input  logic [TE_SIZE-1:0]              te_a,
  input  logic [TE_SIZE-1:0]              te_b,
  input  logic [MANT_SIZE-1:0]            mant_a,
  input  logic [MANT_SIZE-1:0]            mant_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MANT_SUB_RESULT_SIZE-1:0] mant,
  output logic [TE_SIZE-1:0]              te_diff,
  output logic                            sign,
  output logic                            sticky,
  output logic                            is_zero
);

  localparam int R  = MANT_SUB_RESULT_SIZE;
  localparam int SW = TE_SIZE + 1;
  localparam int PAD = R - MANT_SIZE;

  // Stage 1 state
  logic                 s1_valid_q, s1_valid_d;
  logic [MANT_SIZE-1:0] s1_mant_big_q, s1_mant_big_d;
  logic [MANT_SIZE-1:0] s1_mant_small_q, s1_mant_small_d;
  logic [TE_SIZE-1:0]   s1_te_big_q, s1_te_big_d;
  logic                 s1_sign_big_q, s1_sign_big_d;
  logic [SW-1:0]        s1_shift_q, s1_shift_d;

  // Stage 2 (output) state
  logic                 out_valid_q, out_valid_d;
  logic [R-1:0]         mant_q, mant_d;
  logic [TE_SIZE-1:0]   te_diff_q, te_diff_d;
  logic                 sign_q, sign_d;
  logic                 sticky_q, sticky_d;
  logic                 is_zero_q, is_zero_d;

  logic s2_load, s1_advance, s1_load;

  // Ready ripples combinationally from out_ready so a full pipe still streams.
  assign s2_load    = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_load;
  assign s1_load    = !s1_valid_q || s1_advance;
  assign in_ready   = s1_load;

  // Stage 1: order by magnitude (signed exponent first, ties go to a).
  logic               a_big;
  logic [TE_SIZE-1:0] te_small;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    s1_valid_d      = s1_valid_q;
    s1_mant_big_d   = s1_mant_big_q;
    s1_mant_small_d = s1_mant_small_q;
    s1_te_big_d     = s1_te_big_q;
    s1_sign_big_d   = s1_sign_big_q;
    s1_shift_d      = s1_shift_q;
    te_small        = te_b;

    a_big = ($signed(te_a) > $signed(te_b)) ||
            ((te_a == te_b) && (mant_a >= mant_b));

    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_mant_big_d   = a_big ? mant_a : mant_b;
        s1_mant_small_d = a_big ? mant_b : mant_a;
        s1_te_big_d     = a_big ? te_a   : te_b;
        s1_sign_big_d   = a_big ? sign_a : sign_b;
        te_small        = a_big ? te_b   : te_a;
        s1_shift_d      = {s1_te_big_d[TE_SIZE-1], s1_te_big_d} -
                          {te_small[TE_SIZE-1], te_small};
      end
    end
  end

  // Stage 2: align the small operand, collect sticky, subtract.
  logic [R-1:0] big_ext, small_full, small_ext, diff;
  logic         lost;
  always_comb begin
    out_valid_d = out_valid_q;
    mant_d      = mant_q;
    te_diff_d   = te_diff_q;
    sign_d      = sign_q;
    sticky_d    = sticky_q;
    is_zero_d   = is_zero_q;

    big_ext    = {s1_mant_big_q, {PAD{1'b0}}};
    small_full = {s1_mant_small_q, {PAD{1'b0}}};
    if (32'(s1_shift_q) >= 32'(R)) begin
      small_ext = '0;
      lost      = |s1_mant_small_q;
    end else begin
      small_ext = small_full >> s1_shift_q;
      lost      = |(small_full & ~({R{1'b1}} << s1_shift_q));
    end
    diff = big_ext - small_ext;

    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_advance) begin
        mant_d    = diff;
        te_diff_d = s1_te_big_q;
        sticky_d  = lost;
        is_zero_d = (diff == '0) && !lost;
        sign_d    = is_zero_d ? 1'b0 : s1_sign_big_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all datapath registers are reset too (not just valids) so outputs read 0 after reset.
    if (!rst) begin
      s1_valid_q      <= 1'b0;
      s1_mant_big_q   <= '0;
      s1_mant_small_q <= '0;
      s1_te_big_q     <= '0;
      s1_sign_big_q   <= 1'b0;
      s1_shift_q      <= '0;
      out_valid_q     <= 1'b0;
      mant_q          <= '0;
      te_diff_q       <= '0;
      sign_q          <= 1'b0;
      sticky_q        <= 1'b0;
      is_zero_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid_q      <= s1_valid_d;
      s1_mant_big_q   <= s1_mant_big_d;
      s1_mant_small_q <= s1_mant_small_d;
      s1_te_big_q     <= s1_te_big_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_shift_q      <= s1_shift_d;
      out_valid_q     <= out_valid_d;
      mant_q          <= mant_d;
      te_diff_q       <= te_diff_d;
      sign_q          <= sign_d;
      sticky_q        <= sticky_d;
      is_zero_q       <= is_zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign mant      = mant_q;
  assign te_diff   = te_diff_q;
  assign sign      = sign_q;
  assign sticky    = sticky_q;
  assign is_zero   = is_zero_q;

endmodule

// File: tb/tb_core_align_sub_pipe.sv
// Directed bench for core_align_sub_pipe: single ops, stall/stream, and mid-flight reset.
// Result vectors are packed as {mant[15:0], te_diff[5:0], sign, sticky, is_zero}.
module tb_core_align_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        sign_a, sign_b;
  logic [5:0]  te_a, te_b;
  logic [7:0]  mant_a, mant_b;
  logic        out_valid, out_ready;
  logic [15:0] mant;
  logic [5:0]  te_diff;
  logic        sign, sticky, is_zero;

  logic [24:0] got;
  assign got = {mant, te_diff, sign, sticky, is_zero};

  int n_cmp = 0;
  int n_bad = 0;

  core_align_sub_pipe #(
    .N(16), .MANT_SIZE(8), .TE_SIZE(6), .MANT_SUB_RESULT_SIZE(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b),
    .te_a(te_a), .te_b(te_b),
    .mant_a(mant_a), .mant_b(mant_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant(mant), .te_diff(te_diff), .sign(sign),
    .sticky(sticky), .is_zero(is_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic sa, input logic [5:0] ta, input logic [7:0] ma,
                       input logic sb, input logic [5:0] tb_, input logic [7:0] mb);
    sign_a = sa; te_a = ta; mant_a = ma;
    sign_b = sb; te_b = tb_; mant_b = mb;
    in_valid = 1'b1;
  endtask

  // Presents one pair to an empty pipe with out_ready=1 and samples the
  // result one and two edges later.
  task automatic run_pair(input logic sa, input logic [5:0] ta, input logic [7:0] ma,
                          input logic sb, input logic [5:0] tb_, input logic [7:0] mb,
                          output logic rdy, output logic v_early,
                          output logic v_late, output logic [24:0] res);
    @(negedge clk);
    out_ready = 1'b1;
    drive(sa, ta, ma, sb, tb_, mb);
    #1 rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
    #1 v_early = out_valid;
    @(negedge clk);
    #1 v_late = out_valid;
    res = got;
  endtask

  task automatic test_reset;
    logic [24:0] zero_vec;
    zero_vec = '0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign_a = 0; sign_b = 0; te_a = '0; te_b = '0; mant_a = '0; mant_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (got !== zero_vec) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", got, zero_vec); end
  endtask

  task automatic test_align;
    logic rdy, ve, vl; logic [24:0] res, exp_v;
    exp_v = {16'h4000, 6'd3, 1'b0, 1'b0, 1'b0};
    run_pair(1'b0, 6'd3, 8'h80, 1'b1, 6'd2, 8'h80, rdy, ve, vl, res);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL align_in_ready: got %b want 1", rdy); end
    n_cmp++; if (ve !== 1'b0) begin n_bad++; $display("FAIL align_latency_early: out_valid got %b want 0", ve); end
    n_cmp++; if (vl !== 1'b1) begin n_bad++; $display("FAIL align_latency: out_valid got %b want 1", vl); end
    n_cmp++; if (res !== exp_v) begin n_bad++; $display("FAIL align_result: got %h want %h", res, exp_v); end
  endtask

  task automatic test_swap;
    logic rdy, ve, vl; logic [24:0] res, exp_v;
    // Equal exponents, b larger mantissa.
    exp_v = {16'h1000, 6'd1, 1'b1, 1'b0, 1'b0};
    run_pair(1'b0, 6'd1, 8'h90, 1'b1, 6'd1, 8'hA0, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL swap_mant: valid %b got %h want %h", vl, res, exp_v); end
    // Signed exponents: te_a=-1 is smaller than te_b=+1; shift 2.
    exp_v = {16'h4040, 6'd1, 1'b1, 1'b0, 1'b0};
    run_pair(1'b0, 6'h3F, 8'hFF, 1'b1, 6'd1, 8'h80, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL swap_signed_te: valid %b got %h want %h", vl, res, exp_v); end
  endtask

  task automatic test_cancel;
    logic rdy, ve, vl; logic [24:0] res, exp_v;
    exp_v = {16'h0000, 6'd0, 1'b0, 1'b0, 1'b1};
    run_pair(1'b0, 6'd0, 8'hC0, 1'b0, 6'd0, 8'hC0, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL cancel_zero: valid %b got %h want %h", vl, res, exp_v); end
    // Negative big operand cancelling: sign forced to 0.
    exp_v = {16'h0000, 6'd5, 1'b0, 1'b0, 1'b1};
    run_pair(1'b1, 6'd5, 8'hB0, 1'b0, 6'd5, 8'hB0, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL cancel_sign_forced: valid %b got %h want %h", vl, res, exp_v); end
  endtask

  task automatic test_sticky;
    logic rdy, ve, vl; logic [24:0] res, exp_v;
    exp_v = {16'h8000, 6'd20, 1'b0, 1'b1, 1'b0};
    run_pair(1'b0, 6'd20, 8'h80, 1'b0, 6'd0, 8'hFF, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL sticky_saturate20: valid %b got %h want %h", vl, res, exp_v); end
    exp_v = {16'h8000, 6'd16, 1'b0, 1'b1, 1'b0};
    run_pair(1'b0, 6'd16, 8'h80, 1'b0, 6'd0, 8'h81, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL sticky_saturate16: valid %b got %h want %h", vl, res, exp_v); end
    exp_v = {16'h7FFF, 6'd15, 1'b0, 1'b1, 1'b0};
    run_pair(1'b0, 6'd15, 8'h80, 1'b0, 6'd0, 8'h81, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL sticky_shift15: valid %b got %h want %h", vl, res, exp_v); end
    exp_v = {16'h7FC1, 6'd10, 1'b0, 1'b1, 1'b0};
    run_pair(1'b0, 6'd10, 8'h80, 1'b0, 6'd0, 8'hFF, rdy, ve, vl, res);
    n_cmp++; if (vl !== 1'b1 || res !== exp_v) begin n_bad++; $display("FAIL sticky_shift10: valid %b got %h want %h", vl, res, exp_v); end
  endtask

  task automatic test_back_to_back;
    logic        op_sa[4], op_sb[4];
    logic [5:0]  op_ta[4], op_tb[4];
    logic [7:0]  op_ma[4], op_mb[4];
    logic [24:0] exp_q[4];
    logic [24:0] held;
    bit          held_v;
    int          sent, rcvd, drop_at;
    op_sa = '{1'b0, 1'b0, 1'b0, 1'b1};
    op_ta = '{6'd2, 6'h3F, 6'd10, 6'd5};
    op_ma = '{8'h80, 8'hFF, 8'h80, 8'hB0};
    op_sb = '{1'b0, 1'b1, 1'b0, 1'b0};
    op_tb = '{6'd0, 6'd1, 6'd0, 6'd5};
    op_mb = '{8'hC0, 8'h80, 8'hFF, 8'hB0};
    exp_q = '{{16'h5000, 6'd2, 1'b0, 1'b0, 1'b0},
              {16'h4040, 6'd1, 1'b1, 1'b0, 1'b0},
              {16'h7FC1, 6'd10, 1'b0, 1'b1, 1'b0},
              {16'h0000, 6'd5, 1'b0, 1'b0, 1'b1}};
    sent = 0; rcvd = 0; drop_at = -1; held = '0; held_v = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      if (sent < 4) drive(op_sa[sent], op_ta[sent], op_ma[sent],
                          op_sb[sent], op_tb[sent], op_mb[sent]);
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        if (held_v) begin
          n_cmp++; if (got !== held) begin n_bad++; $display("FAIL stall_hold cyc %0d: got %h want %h", cyc, got, held); end
        end else begin
          n_cmp++; if (got !== exp_q[0]) begin n_bad++; $display("FAIL stall_first: got %h want %h", got, exp_q[0]); end
        end
        held = got; held_v = 1;
      end
      if (!in_ready && drop_at < 0) drop_at = sent;
      if (out_valid && out_ready) begin
        if (rcvd < 4) begin
          n_cmp++; if (got !== exp_q[rcvd]) begin n_bad++; $display("FAIL stream_order[%0d]: got %h want %h", rcvd, got, exp_q[rcvd]); end
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    n_cmp++; if (drop_at !== 2) begin n_bad++; $display("FAIL stream_ready_drop: accepts before drop %0d want 2", drop_at); end
    n_cmp++; if (rcvd !== 4) begin n_bad++; $display("FAIL stream_count: got %0d results want 4", rcvd); end
  endtask

  task automatic test_reset_inflight;
    logic rdy, ve, vl; logic [24:0] res, exp_v, zero_vec;
    zero_vec = '0;
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b0, 6'd3, 8'h80, 1'b1, 6'd2, 8'h80);
    @(negedge clk);
    drive(1'b0, 6'd2, 8'h80, 1'b0, 6'd0, 8'hC0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_fill: out_valid %b in_ready %b want 1 0", out_valid, in_ready); end
    // Reset cycle with a handshake offered that must be ignored.
    rst = 1'b0; out_ready = 1'b1;
    drive(1'b0, 6'd1, 8'hF0, 1'b0, 6'd0, 8'h80);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (got !== zero_vec) begin n_bad++; $display("FAIL rst_outputs: got %h want %h", got, zero_vec); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ignored_handshake: out_valid %b want 0", out_valid); end
    exp_v = {16'h1000, 6'd1, 1'b1, 1'b0, 1'b0};
    run_pair(1'b0, 6'd1, 8'h90, 1'b1, 6'd1, 8'hA0, rdy, ve, vl, res);
    n_cmp++; if (ve !== 1'b0 || vl !== 1'b1) begin n_bad++; $display("FAIL rst_post_latency: early %b late %b want 0 1", ve, vl); end
    n_cmp++; if (res !== exp_v) begin n_bad++; $display("FAIL rst_post_result: got %h want %h", res, exp_v); end
  endtask

  initial begin
    test_reset();
    test_align();
    test_swap();
    test_cancel();
    test_sticky();
    test_back_to_back();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
